// File: rtl/ola_pkg.sv
// ---------------------------------------------------------------------------
// ola_pkg
// Shared types and sizing helpers for the overlap-add synthesis block.
//   ola_state_e      : controller states (CLEAR, ACCUM, DRAIN)
//   ola_overlap_log2 : log2 of the overlap factor FRAME_SIZE/HOP_SIZE
//   ola_acc_w        : accumulator entry width, sample width plus overlap growth
// ---------------------------------------------------------------------------
package ola_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } ola_state_e;

  function automatic int ola_overlap_log2(input int frame_size, input int hop_size);
    return $clog2(frame_size / hop_size);
  endfunction

  // Up to FRAME_SIZE/HOP_SIZE frames overlap on any one output sample.
  function automatic int ola_acc_w(input int sample_width, input int frame_size,
                                   input int hop_size);
    return sample_width + ola_overlap_log2(frame_size, hop_size);
  endfunction

endpackage

// File: rtl/ola_saturate.sv
// ---------------------------------------------------------------------------
// ola_saturate
// Combinational conversion of an ACC_W-bit accumulated sum down to a
// SAMPLE_WIDTH-bit output sample.
//   Build option OLA_SATURATE_EN:
//     defined   -> clamp to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]
//     undefined -> keep the low SAMPLE_WIDTH bits (two's-complement wrap)
// Ports:
//   acc    in  ACC_W        signed accumulated sum
//   sample out SAMPLE_WIDTH signed converted sample
// ---------------------------------------------------------------------------
module ola_saturate #(
  parameter int ACC_W        = 17,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic signed [ACC_W-1:0]        acc,
  output logic signed [SAMPLE_WIDTH-1:0] sample
);

`ifdef OLA_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  function automatic logic signed [SAMPLE_WIDTH-1:0] convert(
    input logic signed [ACC_W-1:0] a
  );
    if (a > SAT_MAX)      return SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[SAMPLE_WIDTH-1:0];
    else                  return a[SAMPLE_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [SAMPLE_WIDTH-1:0] convert(
    input logic signed [ACC_W-1:0] a
  );
    return a[SAMPLE_WIDTH-1:0];
  endfunction
`endif

  assign sample = convert(acc);

endmodule

// File: rtl/overlap_add_synth.sv
// ---------------------------------------------------------------------------
// overlap_add_synth
// Overlap-add reconstruction of a sample stream from windowed frames of
// FRAME_SIZE samples advanced by HOP_SIZE. Each accepted frame is summed into
// a circular accumulator RAM; afterwards the oldest HOP_SIZE sums are drained
// to the output (and zeroed) and the window base advances by HOP_SIZE.
// Build option OLA_SATURATE_EN selects clamping instead of wrap on output
// (implemented in ola_saturate).
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_sample in   windowed frame sample, signed
//   frame_valid  in   frame_sample valid
//   in_ready     out  frame sample accepted this cycle when valid
//   out_sample   out  reconstructed sample, signed, registered
//   out_valid    out  out_sample valid, registered
//   out_ready    in   downstream accepts out_sample
// ---------------------------------------------------------------------------
module overlap_add_synth
  import ola_pkg::*;
#(
  parameter int FRAME_SIZE   = 256,
  parameter int HOP_SIZE     = 128,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] frame_sample,
  input  logic                           frame_valid,
  output logic                           in_ready,
  output logic signed [SAMPLE_WIDTH-1:0] out_sample,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int ACC_W = ola_acc_w(SAMPLE_WIDTH, FRAME_SIZE, HOP_SIZE);
  localparam int AW    = $clog2(FRAME_SIZE);
  localparam int KW    = (HOP_SIZE > 1) ? $clog2(HOP_SIZE) : 1;

  localparam logic [AW-1:0] LAST_N  = AW'(FRAME_SIZE - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(HOP_SIZE - 1);
  localparam logic [AW-1:0] HOP_ADV = AW'(HOP_SIZE);

  ola_state_e    state;
  logic [AW-1:0] base;
  logic [AW-1:0] n;      // frame sample index in ACCUM, clear pointer in CLEAR
  logic [KW-1:0] k;

  logic signed [ACC_W-1:0] mem [FRAME_SIZE];

  logic                           accept;
  logic                           xfer;
  logic [AW-1:0]                  acc_addr;
  logic [AW-1:0]                  drain_addr;
  logic [AW-1:0]                  next_addr;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [SAMPLE_WIDTH-1:0] next_sample;

  logic                    mem_we;
  logic [AW-1:0]           mem_wa;
  logic signed [ACC_W-1:0] mem_wd;

  // Accumulate path and RAM write port: same-cycle read-modify-write
  always_comb begin
    accept     = (state == ACCUM) && frame_valid && in_ready;
    xfer       = (state == DRAIN) && out_valid && out_ready;
    acc_addr   = base + n;
    drain_addr = base + AW'(k);
    // Entry to load into out_sample next: hop start when a frame completes,
    // otherwise the entry following the one just transferred.
    next_addr  = (state == DRAIN) ? drain_addr + AW'(1) : base;
    acc_sum    = mem[acc_addr] + ACC_W'(frame_sample);

    mem_we = 1'b0;
    mem_wa = n;
    mem_wd = '0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = n;
      end
      ACCUM: begin
        mem_we = accept;
        mem_wa = acc_addr;
        mem_wd = acc_sum;
      end
      DRAIN: begin
        mem_we = xfer;
        mem_wa = drain_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  ola_saturate #(
    .ACC_W       (ACC_W),
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_sat (
    .acc   (mem[next_addr]),
    .sample(next_sample)
  );

  // Controller and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      base       <= '0;
      n          <= '0;
      k          <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      case (state)
        CLEAR: begin
          n <= n + AW'(1);
          if (n == LAST_N) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            n <= n + AW'(1);
            if (n == LAST_N) begin
              state      <= DRAIN;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              out_sample <= next_sample;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (k == LAST_K) begin
              k          <= '0;
              base       <= base + HOP_ADV;
              state      <= ACCUM;
              in_ready   <= 1'b1;
              out_valid  <= 1'b0;
              out_sample <= '0;
            end else begin
              k          <= k + KW'(1);
              out_sample <= next_sample;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_overlap_add_synth.sv
// ---------------------------------------------------------------------------
// tb_overlap_add_synth
// Directed bench for overlap_add_synth with FRAME_SIZE=8, HOP_SIZE=4,
// SAMPLE_WIDTH=16. Inputs are driven 1 time unit after each rising edge and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_overlap_add_synth;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] frame_sample;
  logic               frame_valid;
  logic               in_ready;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef OLA_SATURATE_EN
  localparam int SAT_POS = 32767;
  localparam int SAT_NEG = -32768;
`else
  localparam int SAT_POS = -25536;   // 40000 wrapped to 16 bits
  localparam int SAT_NEG = 25536;    // -40000 wrapped to 16 bits
`endif

  overlap_add_synth #(
    .FRAME_SIZE  (8),
    .HOP_SIZE    (4),
    .SAMPLE_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_sample(frame_sample),
    .frame_valid (frame_valid),
    .in_ready    (in_ready),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("reset_clear_done", in_ready, 1);
  endtask

  // Sends one 8-sample frame with sample i = a + i*step.
  task automatic send_frame(input string tag, input int a, input int step);
    int guard;
    for (int i = 0; i < 8; i++) begin
      frame_valid  = 1'b1;
      frame_sample = 16'(a + i * step);
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk({tag, "_ready_timeout"}, in_ready, 1);
      tick();
    end
    frame_valid = 1'b0;
    chk({tag, "_latency_vld"}, out_valid, 1);
  endtask

  // Drains cnt samples of a hop with out_ready held high.
  task automatic drain_hop(input string tag, input int cnt,
                           input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    int guard;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    out_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      guard = 0;
      while (!out_valid && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk({tag, "_valid_timeout"}, out_valid, 1);
      chk({tag, "_data"}, out_sample, exp_v[i]);
      chk({tag, "_in_ready_low"}, in_ready, 0);
      tick();
    end
    if (cnt == 4) begin
      chk({tag, "_vld_drop"}, out_valid, 0);
      chk({tag, "_in_ready_rise"}, in_ready, 1);
    end
  endtask

  logic pat [4];
  int   xfers;
  int   cyc;
  logic signed [15:0] held;
  logic stalled;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset and clear: frame_valid held high throughout
    rst_n        = 1'b0;
    frame_valid  = 1'b1;
    frame_sample = 16'sd999;
    out_ready    = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("clr_in_ready", in_ready, 0);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_out_sample", out_sample, 0);
      tick();
    end
    chk("clr_in_ready_rise", in_ready, 1);
    frame_valid = 1'b0;

    // Constant input: three frames of 1000
    send_frame("const_f0", 1000, 0);
    drain_hop("const_h1", 4, 1000, 1000, 1000, 1000);
    send_frame("const_f1", 1000, 0);
    drain_hop("const_h2", 4, 2000, 2000, 2000, 2000);
    send_frame("const_f2", 1000, 0);
    drain_hop("const_h3", 4, 2000, 2000, 2000, 2000);

    // Ramp
    do_reset();
    send_frame("ramp_f0", 0, 1);
    drain_hop("ramp_h1", 4, 0, 1, 2, 3);
    send_frame("ramp_f1", 10, 1);
    drain_hop("ramp_h2", 4, 14, 16, 18, 20);

    // Positive and negative overflow
    do_reset();
    send_frame("satp_f0", 20000, 0);
    drain_hop("satp_h1", 4, 20000, 20000, 20000, 20000);
    send_frame("satp_f1", 20000, 0);
    drain_hop("satp_h2", 4, SAT_POS, SAT_POS, SAT_POS, SAT_POS);
    do_reset();
    send_frame("satn_f0", -20000, 0);
    drain_hop("satn_h1", 4, -20000, -20000, -20000, -20000);
    send_frame("satn_f1", -20000, 0);
    drain_hop("satn_h2", 4, SAT_NEG, SAT_NEG, SAT_NEG, SAT_NEG);

    // Backpressure: out_ready pattern 1,0,0,1 repeating, frame_valid held
    do_reset();
    send_frame("bp_f0", 0, 1);
    frame_valid  = 1'b1;
    frame_sample = 16'sd777;
    xfers   = 0;
    cyc     = 0;
    held    = '0;
    stalled = 1'b0;
    while (out_valid && cyc < 40) begin
      out_ready = pat[cyc % 4];
      chk("bp_in_ready_low", in_ready, 0);
      if (out_ready) begin
        chk("bp_data", out_sample, xfers);
        xfers++;
        stalled = 1'b0;
      end else begin
        held    = out_sample;
        stalled = 1'b1;
      end
      tick();
      cyc++;
      if (stalled) begin
        chk("bp_hold_data", out_sample, held);
        chk("bp_hold_vld", out_valid, 1);
      end
    end
    frame_valid = 1'b0;
    out_ready   = 1'b1;
    chk("bp_xfer_count", xfers, 4);
    chk("bp_in_ready_rise", in_ready, 1);
    // A sample taken during the stall would shift this hop's alignment.
    send_frame("bp_f1", 0, 0);
    drain_hop("bp_h2", 4, 4, 5, 6, 7);

    // Reset in the middle of a drain
    do_reset();
    send_frame("mrst_f0", 3000, 0);
    drain_hop("mrst_part", 2, 3000, 3000, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_sample", out_sample, 0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("mrst_reclear", in_ready, 1);
    send_frame("mrst_f1", 500, 0);
    drain_hop("mrst_h1", 4, 500, 500, 500, 500);
    send_frame("mrst_f2", 500, 0);
    drain_hop("mrst_h2", 4, 1000, 1000, 1000, 1000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
